// File: rtl/sseg_value_writer.sv
// Converts a signed value to BCD and writes it digit by digit to a chain of seven-segment modules.
// Optional leading-zero blanking: define SSEG_VALUE_WRITER_BLANK_EN.
module sseg_value_writer #(
  parameter int SSEG_BITS = 2,
  parameter int SSEG_N    = 3,
  parameter int VAL_BITS  = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic signed [VAL_BITS-1:0] value,
  input  logic                       dp_en,
  input  logic [SSEG_BITS-1:0]       dp_pos,
  output logic                       wr,
  output logic [SSEG_BITS-1:0]       sel,
  output logic                       en,
  output logic                       sign,
  output logic                       dp,
  output logic [3:0]                 val,
  output logic                       busy,
  output logic                       ovf,
  output logic                       done_tick
);

  localparam int BCD_W = 4 * SSEG_N;
  localparam int CNT_W = $clog2(VAL_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(VAL_BITS);
  localparam logic [VAL_BITS-1:0] VAL_ONE = {{(VAL_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CONV, WRITE, DONE} state_t;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  // Negative numbers give up the top module to the minus sign.
  localparam longint unsigned LIM_POS = pow10(SSEG_N) - 64'd1;
  localparam longint unsigned LIM_NEG = pow10(SSEG_N - 1) - 64'd1;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int d = 0; d < SSEG_N; d++) begin
      if (r[4*d +: 4] >= 4'd5) begin
        r[4*d +: 4] = r[4*d +: 4] + 4'd3;
      end else begin
        r[4*d +: 4] = r[4*d +: 4];
      end
    end
    return r;
  endfunction

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [VAL_BITS-1:0]   bin_r, mag_r, mag_s;
  logic [BCD_W-1:0]      bcd_r, bcd_adj_s;
  logic                  neg_r, dp_en_r;
  logic [SSEG_BITS-1:0]  dp_pos_r;
  logic                  ovf_calc_s, ovf_s, dp_hit_s;
  logic                  nxt_en_s, nxt_sign_s, nxt_dp_s;
  logic [3:0]            nxt_val_s;
  int                    idx_i, top_i, msnz_i;

  assign bcd_adj_s = add3(bcd_r);

  // Magnitude of the input; the most negative value maps exactly onto the unsigned range.
  always_comb begin
    if (value[VAL_BITS-1]) begin
      mag_s = (~value) + VAL_ONE;
    end else begin
      mag_s = value;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = start ? CONV : IDLE;
      CONV:    state_s = (cnt_r == CNT_END) ? WRITE : CONV;
      WRITE:   state_s = (int'(sel) == SSEG_N - 1) ? DONE : WRITE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Conversion datapath; the load edge already performs the first shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= '0;
      bin_r    <= '0;
      bcd_r    <= '0;
      mag_r    <= '0;
      neg_r    <= 1'b0;
      dp_en_r  <= 1'b0;
      dp_pos_r <= '0;
    end else if (state_r == IDLE && start) begin
      cnt_r    <= CNT_W'(1);
      bin_r    <= mag_s << 1;
      bcd_r    <= BCD_W'(mag_s[VAL_BITS-1]);
      mag_r    <= mag_s;
      neg_r    <= value[VAL_BITS-1];
      dp_en_r  <= dp_en;
      dp_pos_r <= dp_pos;
    end else if (state_r == CONV && cnt_r != CNT_END) begin
      cnt_r <= cnt_r + CNT_W'(1);
      bin_r <= bin_r << 1;
      bcd_r <= {bcd_adj_s[BCD_W-2:0], bin_r[VAL_BITS-1]};
    end else begin
      cnt_r <= cnt_r;
      bin_r <= bin_r;
      bcd_r <= bcd_r;
    end
  end

  // Decode of the module to be written on the coming edge.
  always_comb begin
    idx_i = (state_r == CONV) ? 0 : int'(sel) + 1;
    if (neg_r) begin
      ovf_calc_s = 64'(mag_r) > LIM_NEG;
    end else begin
      ovf_calc_s = 64'(mag_r) > LIM_POS;
    end
    ovf_s  = (state_r == CONV) ? ovf_calc_s : ovf;
    msnz_i = 0;
    for (int d = 0; d < SSEG_N; d++) begin
      if (bcd_r[4*d +: 4] != 4'd0) begin
        msnz_i = d;
      end else begin
        msnz_i = msnz_i;
      end
    end
`ifdef SSEG_VALUE_WRITER_BLANK_EN
    top_i = (dp_en_r && int'(dp_pos_r) > msnz_i) ? int'(dp_pos_r) : msnz_i;
    top_i = (top_i > SSEG_N - 1) ? SSEG_N - 1 : top_i;
`else
    top_i = SSEG_N - 1;
`endif
    top_i    = (neg_r && top_i > SSEG_N - 2) ? SSEG_N - 2 : top_i;
    dp_hit_s = dp_en_r && (int'(dp_pos_r) == idx_i);
    if (ovf_s) begin
      nxt_val_s  = 4'd0;
      nxt_en_s   = 1'b0;
      nxt_sign_s = 1'b1;
      nxt_dp_s   = 1'b0;
    end else if (idx_i <= top_i && idx_i < SSEG_N) begin
      nxt_val_s  = bcd_r[4*idx_i +: 4];
      nxt_en_s   = 1'b1;
      nxt_sign_s = 1'b0;
      nxt_dp_s   = dp_hit_s;
    end else if (neg_r && idx_i == top_i + 1) begin
      nxt_val_s  = 4'd0;
      nxt_en_s   = 1'b0;
      nxt_sign_s = 1'b1;
      nxt_dp_s   = dp_hit_s;
    end else begin
      nxt_val_s  = 4'd0;
      nxt_en_s   = 1'b0;
      nxt_sign_s = 1'b0;
      nxt_dp_s   = dp_hit_s;
    end
  end

  // Registered outputs, loaded alongside the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr        <= 1'b0;
      sel       <= '0;
      en        <= 1'b0;
      sign      <= 1'b0;
      dp        <= 1'b0;
      val       <= 4'd0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      busy <= (state_s != IDLE);
      if (state_r == CONV && state_s == WRITE) begin
        ovf <= ovf_calc_s;
      end else begin
        ovf <= ovf;
      end
      case (state_s)
        WRITE: begin
          wr        <= 1'b1;
          sel       <= SSEG_BITS'(idx_i);
          en        <= nxt_en_s;
          sign      <= nxt_sign_s;
          dp        <= nxt_dp_s;
          val       <= nxt_val_s;
          done_tick <= 1'b0;
        end
        DONE: begin
          wr        <= 1'b0;
          sel       <= '0;
          en        <= 1'b0;
          sign      <= 1'b0;
          dp        <= 1'b0;
          val       <= 4'd0;
          done_tick <= 1'b1;
        end
        default: begin
          wr        <= 1'b0;
          sel       <= '0;
          en        <= 1'b0;
          sign      <= 1'b0;
          dp        <= 1'b0;
          val       <= 4'd0;
          done_tick <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_value_writer.sv
// Scoreboard bench for sseg_value_writer (SSEG_N=3, VAL_BITS=10); expectations follow the blanking build option.
module tb_sseg_value_writer;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] val;
    logic       en;
    logic       sign;
    logic       dp;
  } exp_t;

`ifdef SSEG_VALUE_WRITER_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic signed [9:0] value = 10'sd0;
  logic              dp_en = 1'b0;
  logic [1:0]        dp_pos = 2'd0;
  logic              wr, en, sign, dp, busy, ovf, done_tick;
  logic [1:0]        sel;
  logic [3:0]        val;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  sseg_value_writer #(.SSEG_BITS(2), .SSEG_N(3), .VAL_BITS(10)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .dp_en(dp_en), .dp_pos(dp_pos),
    .wr(wr), .sel(sel), .en(en), .sign(sign), .dp(dp), .val(val),
    .busy(busy), .ovf(ovf), .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int s, input int v, input int e, input int g, input int d);
    exp_t x;
    x.sel  = 2'(s);
    x.val  = 4'(v);
    x.en   = 1'(e);
    x.sign = 1'(g);
    x.dp   = 1'(d);
    return x;
  endfunction

  // Monitor: every write strobe is matched against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t got, want;
    got = '{sel: sel, val: val, en: en, sign: sign, dp: dp};
    checks++;
    if (wr) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got sel=%0d val=%0d en=%0b sign=%0b dp=%0b, none expected",
                 sel, val, en, sign, dp);
      end else begin
        want = q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL write: got sel=%0d val=%0d en=%0b sign=%0b dp=%0b, want sel=%0d val=%0d en=%0b sign=%0b dp=%0b",
                   sel, val, en, sign, dp, want.sel, want.val, want.en, want.sign, want.dp);
        end
      end
    end else if (got !== 9'd0) begin
      errors++;
      $display("FAIL idle_outputs: got sel=%0d val=%0d en=%0b sign=%0b dp=%0b, want all 0",
               sel, val, en, sign, dp);
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // One conversion: queue expected writes, pulse start, then check latency, ovf and return to idle.
  task automatic go(input logic signed [9:0] v, input logic dpe, input logic [1:0] dpp,
                    input exp_t e0, input exp_t e1, input exp_t e2,
                    input logic eovf, input bit rel, input bit glitch);
    int n;
    q.push_back(e0);
    q.push_back(e1);
    q.push_back(e2);
    @(negedge clk);
    if (rel) reset = 1'b0;
    value  = v;
    dp_en  = dpe;
    dp_pos = dpp;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    value  = ~v;
    dp_en  = ~dpe;
    dp_pos = ~dpp;
    n = 1;
    check("busy_after_start", int'(busy), 1);
    while (!done_tick && n < 40) begin
      @(negedge clk);
      n++;
      start = (glitch && (n == 5 || n == 12)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check("done_latency", n, 14);
    check("ovf", int'(ovf), int'(eovf));
    @(negedge clk);
    check("busy_after_done", int'(busy), 0);
    check("done_one_cycle", int'(done_tick), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({wr, sel, en, sign, dp, val, busy, ovf, done_tick}), 0);

    go(10'sd123, 1'b0, 2'd0, mk(0,3,1,0,0), mk(1,2,1,0,0), mk(2,1,1,0,0), 1'b0, 1'b1, 1'b0);
    go(10'sd0, 1'b0, 2'd0, mk(0,0,1,0,0),
       BLANK ? mk(1,0,0,0,0) : mk(1,0,1,0,0), BLANK ? mk(2,0,0,0,0) : mk(2,0,1,0,0), 1'b0, 1'b0, 1'b0);
    go(-10'sd45, 1'b0, 2'd0, mk(0,5,1,0,0), mk(1,4,1,0,0), mk(2,0,0,1,0), 1'b0, 1'b0, 1'b0);
    go(-10'sd100, 1'b0, 2'd0, mk(0,0,0,1,0), mk(1,0,0,1,0), mk(2,0,0,1,0), 1'b1, 1'b0, 1'b0);
    go(10'sd7, 1'b0, 2'd0, mk(0,7,1,0,0),
       BLANK ? mk(1,0,0,0,0) : mk(1,0,1,0,0), BLANK ? mk(2,0,0,0,0) : mk(2,0,1,0,0), 1'b0, 1'b0, 1'b0);
    go(10'sd5, 1'b1, 2'd2, mk(0,5,1,0,0), mk(1,0,1,0,0), mk(2,0,1,0,1), 1'b0, 1'b0, 1'b0);
    go(10'sd511, 1'b0, 2'd0, mk(0,1,1,0,0), mk(1,1,1,0,0), mk(2,5,1,0,0), 1'b0, 1'b0, 1'b0);
    go(-10'sd512, 1'b1, 2'd1, mk(0,0,0,1,0), mk(1,0,0,1,0), mk(2,0,0,1,0), 1'b1, 1'b0, 1'b0);
    go(-10'sd99, 1'b0, 2'd0, mk(0,9,1,0,0), mk(1,9,1,0,0), mk(2,0,0,1,0), 1'b0, 1'b0, 1'b0);
    go(-10'sd9, 1'b0, 2'd0, mk(0,9,1,0,0),
       BLANK ? mk(1,0,0,1,0) : mk(1,0,1,0,0), BLANK ? mk(2,0,0,0,0) : mk(2,0,0,1,0), 1'b0, 1'b0, 1'b0);
    go(-10'sd7, 1'b1, 2'd1, mk(0,7,1,0,0), mk(1,0,1,0,1), mk(2,0,0,1,0), 1'b0, 1'b0, 1'b0);
    go(10'sd123, 1'b0, 2'd0, mk(0,3,1,0,0), mk(1,2,1,0,0), mk(2,1,1,0,0), 1'b0, 1'b0, 1'b1);

    // Abort in the middle of the write burst.
    q.push_back(mk(0,4,1,0,0));
    q.push_back(mk(1,5,1,0,0));
    q.push_back(mk(2,3,1,0,0));
    @(negedge clk);
    value = 10'sd354;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!(wr && sel == 2'd0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("abort_first_write_cycle", n, 11);
    #2 reset = 1'b1;
    #1;
    check("abort_wr", int'(wr), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done_tick), 0);
    q.delete();
    repeat (3) begin
      @(negedge clk);
      check("abort_quiet", int'({wr, done_tick}), 0);
    end
    go(10'sd42, 1'b0, 2'd0, mk(0,2,1,0,0), mk(1,4,1,0,0),
       BLANK ? mk(2,0,0,0,0) : mk(2,0,1,0,0), 1'b0, 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sseg_value_writer.md
SSEG_VALUE_WRITER -- requirements
Module: sseg_value_writer

Interface
REQ-001 SHALL have parameter SSEG_BITS, default 2, meaning width of the module select index.
REQ-002 SHALL have parameter SSEG_N, default 3, meaning the number of seven-segment modules driven (1..2^SSEG_BITS).
REQ-003 SHALL have parameter VAL_BITS, default 10, meaning the width of the signed two's-complement input value.
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: start  in  1  conversion request; value  in  VAL_BITS  signed number; dp_en  in  1  decimal point enable; dp_pos  in  SSEG_BITS  module index carrying the decimal point.
REQ-006 SHALL have ports: wr  out  1  write strobe; sel  out  SSEG_BITS  target module; en  out  1  digit enable; sign  out  1  minus segment; dp  out  1  decimal point; val  out  4  BCD digit.
REQ-007 SHALL have ports: busy  out  1  conversion or write sequence in progress; ovf  out  1  last value did not fit; done_tick  out  1  one-cycle sequence-complete pulse.
REQ-008 SHALL drive all outputs from registers; no combinational path from any input to any output.

Function
REQ-009 SHALL implement states IDLE, CONV, WRITE, DONE.
REQ-010 In IDLE with start=1 at a clock edge, SHALL latch value, dp_en and dp_pos and move to CONV.
REQ-011 SHALL ignore start in any state other than IDLE.
REQ-012 CONV SHALL take exactly VAL_BITS cycles, converting the magnitude |value| (unsigned, VAL_BITS wide, so -2^(VAL_BITS-1) is exact) to SSEG_N BCD digits by shift-and-add-3.
REQ-013 Capacity SHALL be SSEG_N digits for non-negative values and SSEG_N-1 digits for negative values; ovf SHALL be set when the magnitude exceeds 10^capacity-1, and cleared otherwise, at CONV exit.
REQ-014 WRITE SHALL last exactly SSEG_N cycles with wr=1 each cycle and sel = 0, 1, ..., SSEG_N-1 in order (sel 0 = least significant digit).
REQ-015 Non-overflow digit write: val = BCD digit, en=1, sign=0; dp=1 only when dp_en=1 and sel==dp_pos.
REQ-016 Negative non-overflow: the module immediately above the most significant shown digit SHALL be written with en=0, sign=1, dp per REQ-015.
REQ-017 Overflow: every module SHALL be written with en=0, sign=1 (dashes), dp=0, val=0.
REQ-018 DONE SHALL last one cycle with done_tick=1 and wr=0, then return to IDLE.
REQ-019 busy SHALL be 1 in CONV, WRITE and DONE, 0 in IDLE; start to done_tick latency SHALL be VAL_BITS+SSEG_N+1 cycles.
REQ-020 Outside WRITE, wr SHALL be 0 and sel, en, sign, dp, val SHALL be 0.
REQ-021 ovf SHALL hold its value from CONV exit until the next CONV exit.

Reset
REQ-022 Reset SHALL asynchronously force state IDLE and wr, sel, en, sign, dp, val, busy, ovf, done_tick to 0.
REQ-023 Reset asserted mid-CONV or mid-WRITE SHALL abort the sequence with no further wr pulses and no done_tick.
REQ-024 First start accepted SHALL be at the first clock edge after reset deasserts.

Configuration
REQ-025 Macro SSEG_VALUE_WRITER_BLANK_EN SHALL select leading-zero blanking.
REQ-026 With SSEG_VALUE_WRITER_BLANK_EN defined: zero digits above the most significant non-zero digit SHALL be written with en=0 (blank), except sel 0 and, when dp_en=1, any sel <= dp_pos; the minus of REQ-016 moves down to just above the highest shown digit.
REQ-027 Without it: every non-overflow digit SHALL be shown (en=1, leading zeros visible) and the minus SHALL occupy sel SSEG_N-1.

Verification (SSEG_N=3, VAL_BITS=10, BLANK_EN defined)
REQ-028 start, value=123 -> writes (sel,val,en) = (0,3,1),(1,2,1),(2,1,1); ovf=0; done_tick 14 cycles after start.
REQ-029 start, value=0 -> (0,0,en=1),(1,en=0),(2,en=0); sign=0 throughout.
REQ-030 start, value=-45 -> (0,5,1),(1,4,1),(2,en=0,sign=1); ovf=0.
REQ-031 start, value=-100 -> all three writes en=0, sign=1; ovf=1; then value=7 -> ovf=0.
REQ-032 start, value=5, dp_en=1, dp_pos=2 -> (0,5,1),(1,0,1),(2,0,1,dp=1).
REQ-033 reset asserted during WRITE after sel 0 -> wr=0 immediately, no done_tick; start re-accepted after release; start pulsed while busy -> ignored.
